cp0_ctrl: RTL and testbench
===========================

Name: cp0_ctrl

Overview:
- Owns the CP0 register bank (BadVAddr, Count, Compare, Status, Cause, EPC).
- Sequences exception entry and ERET return for the 5-stage pipeline.
- Driven by the write-back stage's exception/mtc0/eret signals. Serves mfc0 reads to write-back.
- Produces the pipeline flush, the redirect PC and the interrupt request that the decode stage uses to tag an instruction.

Parameters:
- EX_ENTRY, 32'hbfc0_0380, exception vector loaded on flush for non-ERET.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ws_ex  in  1  write-back instruction valid and excepting (includes eret)
- ws_eret  in  1  write-back instruction is a valid ERET
- ws_excode  in  5  exception code
- ws_badvaddr  in  32  faulting address
- ws_bd  in  1  instruction is in a delay slot
- ws_pc  in  32  PC of the write-back instruction
- mtc0_we  in  1  valid mtc0 in write-back
- cp0_addr  in  5  CP0 register number (rd, sel=0) for read and write
- cp0_wdata  in  32  mtc0 data (rt value)
- ext_int  in  6  hardware interrupt lines, level-sensitive, already synchronised
- cp0_rdata  out  32  mfc0 read data
- cp0_epc  out  32  current EPC
- int_req  out  1  interrupt pending and enabled
- flush  out  1  flush all pipeline stages
- flush_pc  out  32  redirect target, valid when flush=1

Behaviour:
- Reset (resetn=0 at clk edge):
  - Status=STATUS_RST; Cause, EPC, Count, Compare, BadVAddr all =0.
  - tick=0; TI=0.
  - Outputs: int_req=0, flush=0, cp0_epc=0.
- Reads (combinational):
  - cp0_rdata muxes by cp0_addr: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; any other address returns 0.
  - A read sees the value before the current cycle's write (no bypass).
- Writes (mtc0, applied at clk edge):
  - Ignored when ws_ex=1.
  - Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[1:0] (bits 9:8); EPC all; Count all; Compare all. BadVAddr is read-only.
- Count/tick:
  - tick toggles every cycle; Count increments on cycles where tick=1, giving half-frequency counting and 32-bit wrap 0xffffffff->0.
  - An mtc0 to Count overrides the increment in that cycle; tick is unaffected.
- Timer interrupt (TI):
  - TI<=1 on a cycle where tick=1 and Count==Compare.
  - An mtc0 to Compare clears TI and wins over a simultaneous set.
- Cause.IP[7:2]: registered every cycle from {ext_int[5]|TI, ext_int[4:0]}. Cause bit 30 = TI.
- int_req (combinational from registers) = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Exception entry (ws_ex=1, ws_eret=0):
  - If EXL=0: EPC <= ws_bd ? ws_pc-4 : ws_pc, and Cause.BD <= ws_bd.
  - If EXL=1: EPC and BD are kept.
  - Always: EXL<=1 and Cause.ExcCode[6:2]<=ws_excode.
  - BadVAddr<=ws_badvaddr only for excode 4 (AdEL) or 5 (AdES).
- ERET (ws_ex=1, ws_eret=1): EXL<=0; no other register changes.
- Flush (combinational):
  - flush = ws_ex.
  - flush_pc = ws_eret ? EPC : EX_ENTRY, where EPC is the register value before this cycle's update.
  - Asserted for exactly the cycle ws_ex=1.
- Simultaneous events:
  - Exception update beats mtc0.
  - Hardware IP sampling continues during an exception.
  - Reset beats everything.
- Reset mid-exception: all state returns to reset values; flush=0 from the cycle after.

Decomposition:
- mycpu.h holds:
  - CP0 register numbers (CR_BADVADDR=8, CR_COUNT=9, CR_COMPARE=11, CR_STATUS=12, CR_CAUSE=13, CR_EPC=14).
  - Excode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
  - EX_ENTRY.
- One sub-module, cp0_timer, holds tick, Count, Compare and TI. Ports: write enables, data, count/compare/ti outputs.

Test Plan:
- Reset then read: resetn low 2 cycles; read addr 12 -> 0x00400000; addr 13, 14 and 9 -> 0; flush=0.
- Counter and timer interrupt:
  - Stimulus: mtc0 Compare=5, mtc0 Count=0, Status=0x0000_8001.
  - Required: Count reaches 5 after 10 cycles (±1 for tick phase); next tick cycle TI=1; Cause.IP7=1 one cycle later; int_req=1.
  - Then mtc0 Compare=100: TI=0 and int_req=0 next cycle.
- Delay-slot exception:
  - Stimulus: ws_ex=1, excode=12, ws_pc=0xbfc01004, bd=1.
  - Required: flush=1, flush_pc=0xbfc00380; next cycle EPC=0xbfc01000, Cause=0x8000_0030, Status.EXL=1.
- Nested exception and ERET:
  - Stimulus: with EXL=1, ws_ex excode=4, badvaddr=0x1003.
  - Required: EPC unchanged; BadVAddr=0x1003; ExcCode=4.
  - Then ws_eret: flush_pc=EPC; EXL=0 next cycle.
- Write collision: mtc0_we=1 to EPC with ws_ex=1, pc=0x400 -> EPC=0x400 (mtc0 discarded).
- External interrupt masking:
  - Stimulus: ext_int=6'b000001, IM2=1, IE=1, EXL=1.
  - Required: int_req=0; after ERET, int_req=1 next cycle.

Source files
------------

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, reset/vector values
// and the small decode helpers used by the control block.
package cp0_ctrl_pkg;

    localparam logic [4:0] CR_BADVADDR = 5'd8;
    localparam logic [4:0] CR_COUNT    = 5'd9;
    localparam logic [4:0] CR_COMPARE  = 5'd11;
    localparam logic [4:0] CR_STATUS   = 5'd12;
    localparam logic [4:0] CR_CAUSE    = 5'd13;
    localparam logic [4:0] CR_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } excode_e;

    localparam logic [31:0] CP0_EX_ENTRY     = 32'hbfc0_0380;
    localparam logic [31:0] CP0_STATUS_RST   = 32'h0040_0000;
    // Software-writable Status bits: IM[15:8], EXL, IE
    localparam logic [31:0] STATUS_WR_MASK   = 32'h0000_ff03;

    function automatic logic is_addr_exc(input logic [4:0] excode);
        return (excode == EXC_ADEL) || (excode == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: half-rate counter, compare register and the
// timer-interrupt flag TI.
module cp0_timer
    import cp0_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Tick phase and counter; a software write replaces the increment
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick  <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_tick <= ~r_tick;
            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Compare register and timer flag; writing Compare acknowledges TI
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else if (i_compare_we) begin
            r_compare <= i_wdata;
            r_ti      <= 1'b0;
        end else if (r_tick && (r_count == r_compare)) begin
            r_compare <= r_compare;
            r_ti      <= 1'b1;
        end else begin
            r_compare <= r_compare;
            r_ti      <= r_ti;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register bank with exception entry / ERET sequencing, pipeline flush,
// redirect target and interrupt request generation.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY   = CP0_EX_ENTRY,
    parameter logic [31:0] STATUS_RST = CP0_STATUS_RST
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [4:0]  ws_excode,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_bd,
    input  logic [31:0] ws_pc,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  ext_int,
    output logic [31:0] cp0_rdata,
    output logic [31:0] cp0_epc,
    output logic        int_req,
    output logic        flush,
    output logic [31:0] flush_pc
);

    logic [31:0] r_status;
    logic        r_cause_bd;
    logic [7:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_mtc0;
    logic        w_exc;
    logic        w_exl;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_cause;

    // Any write-back exception (including ERET) squashes a concurrent mtc0
    assign w_mtc0 = mtc0_we & ~ws_ex;
    assign w_exc  = ws_ex & ~ws_eret;
    assign w_exl  = r_status[1];

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_mtc0 && (cp0_addr == CR_COUNT)),
        .i_compare_we (w_mtc0 && (cp0_addr == CR_COMPARE)),
        .i_wdata      (cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Status: exception/ERET only move EXL; mtc0 touches writable fields
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_status <= STATUS_RST;
        end else if (ws_ex) begin
            r_status <= {r_status[31:2], ~ws_eret, r_status[0]};
        end else if (w_mtc0 && (cp0_addr == CR_STATUS)) begin
            r_status <= (r_status & ~STATUS_WR_MASK) | (cp0_wdata & STATUS_WR_MASK);
        end else begin
            r_status <= r_status;
        end
    end

    // Cause: hardware IP sampled every cycle, software IP[1:0], exception fields
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cause_ip  <= 8'd0;
            r_cause_bd  <= 1'b0;
            r_cause_exc <= 5'd0;
        end else begin
            r_cause_ip[7:2] <= {ext_int[5] | w_ti, ext_int[4:0]};
            if (w_mtc0 && (cp0_addr == CR_CAUSE)) begin
                r_cause_ip[1:0] <= cp0_wdata[9:8];
            end else begin
                r_cause_ip[1:0] <= r_cause_ip[1:0];
            end
            if (w_exc) begin
                r_cause_exc <= ws_excode;
                r_cause_bd  <= w_exl ? r_cause_bd : ws_bd;
            end else begin
                r_cause_exc <= r_cause_exc;
                r_cause_bd  <= r_cause_bd;
            end
        end
    end

    // EPC: a nested exception (EXL already set) keeps the original return point
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_epc <= 32'd0;
        end else if (w_exc) begin
            if (!w_exl) begin
                r_epc <= ws_bd ? (ws_pc - 32'd4) : ws_pc;
            end else begin
                r_epc <= r_epc;
            end
        end else if (w_mtc0 && (cp0_addr == CR_EPC)) begin
            r_epc <= cp0_wdata;
        end else begin
            r_epc <= r_epc;
        end
    end

    // BadVAddr captures the faulting address on address-error exceptions only
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_badvaddr <= 32'd0;
        end else if (w_exc && is_addr_exc(ws_excode)) begin
            r_badvaddr <= ws_badvaddr;
        end else begin
            r_badvaddr <= r_badvaddr;
        end
    end

    assign w_cause = {r_cause_bd, w_ti, 14'd0, r_cause_ip, 1'b0, r_cause_exc, 2'b00};

    // mfc0 read mux, reflecting register state before this cycle's update
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            CR_BADVADDR: cp0_rdata = r_badvaddr;
            CR_COUNT:    cp0_rdata = w_count;
            CR_COMPARE:  cp0_rdata = w_compare;
            CR_STATUS:   cp0_rdata = r_status;
            CR_CAUSE:    cp0_rdata = w_cause;
            CR_EPC:      cp0_rdata = r_epc;
            default:     cp0_rdata = 32'd0;
        endcase
    end

    assign cp0_epc  = r_epc;
    assign int_req  = r_status[0] & ~w_exl & (|(r_cause_ip & r_status[15:8]));
    assign flush    = ws_ex;
    assign flush_pc = ws_eret ? r_epc : EX_ENTRY;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed self-checking bench for cp0_ctrl: reset, timer interrupt,
// exception entry/nesting/ERET, write collision and interrupt masking.
module tb_cp0_ctrl;

    logic        clk;
    logic        resetn;
    logic        ws_ex;
    logic        ws_eret;
    logic [4:0]  ws_excode;
    logic [31:0] ws_badvaddr;
    logic        ws_bd;
    logic [31:0] ws_pc;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [5:0]  ext_int;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic        int_req;
    logic        flush;
    logic [31:0] flush_pc;

    int n_checks;
    int n_errors;

    cp0_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .ws_ex       (ws_ex),
        .ws_eret     (ws_eret),
        .ws_excode   (ws_excode),
        .ws_badvaddr (ws_badvaddr),
        .ws_bd       (ws_bd),
        .ws_pc       (ws_pc),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .ext_int     (ext_int),
        .cp0_rdata   (cp0_rdata),
        .cp0_epc     (cp0_epc),
        .int_req     (int_req),
        .flush       (flush),
        .flush_pc    (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        cp0_addr = a;
        #1;
        check_val(tag, cp0_rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mtc0_we   = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
        cyc();
        mtc0_we   = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        resetn      = 1'b0;
        ws_ex       = 1'b0;
        ws_eret     = 1'b0;
        ws_excode   = 5'd0;
        ws_badvaddr = 32'd0;
        ws_bd       = 1'b0;
        ws_pc       = 32'd0;
        mtc0_we     = 1'b0;
        cp0_addr    = 5'd0;
        cp0_wdata   = 32'd0;
        ext_int     = 6'd0;

        cyc();
        cyc();
        resetn = 1'b1;
        rd(5'd12, 32'h0040_0000, "rst_status");
        rd(5'd13, 32'h0000_0000, "rst_cause");
        rd(5'd14, 32'h0000_0000, "rst_epc");
        rd(5'd9,  32'h0000_0000, "rst_count");
        check_val("rst_flush",   {31'd0, flush},   32'd0);
        check_val("rst_int_req", {31'd0, int_req}, 32'd0);
        check_val("rst_cp0_epc", cp0_epc,          32'd0);

        // Timer: Compare=5, Count=0, Status IM7|IE; Count advances every other edge
        wr(5'd11, 32'd5);
        wr(5'd9,  32'd0);
        wr(5'd12, 32'h0000_8001);
        repeat (9) cyc();
        rd(5'd9,  32'd5, "count_eq_compare");
        cyc();
        rd(5'd13, 32'h0000_0000, "ti_not_yet");
        cyc();
        rd(5'd13, 32'h4000_0000, "ti_set");
        check_val("int_req_before_ip7", {31'd0, int_req}, 32'd0);
        cyc();
        rd(5'd13, 32'h4000_8000, "ip7_set");
        check_val("int_req_timer", {31'd0, int_req}, 32'd1);
        wr(5'd11, 32'd100);
        rd(5'd13, 32'h0000_8000, "ti_cleared");
        cyc();
        rd(5'd13, 32'h0000_0000, "ip7_cleared");
        check_val("int_req_timer_off", {31'd0, int_req}, 32'd0);

        // Overflow exception from a delay slot
        ws_ex = 1'b1; ws_excode = 5'd12; ws_pc = 32'hbfc0_1004; ws_bd = 1'b1;
        ws_badvaddr = 32'hdead_beef;
        #1;
        check_val("ds_flush",    {31'd0, flush}, 32'd1);
        check_val("ds_flush_pc", flush_pc, 32'hbfc0_0380);
        cyc();
        ws_ex = 1'b0; ws_bd = 1'b0;
        #1;
        check_val("ds_flush_drop", {31'd0, flush}, 32'd0);
        check_val("ds_cp0_epc", cp0_epc, 32'hbfc0_1000);
        rd(5'd13, 32'h8000_0030, "ds_cause");
        rd(5'd12, 32'h0040_8003, "ds_status");
        rd(5'd8,  32'h0000_0000, "ds_badvaddr");

        // Nested AdEL while EXL=1
        ws_ex = 1'b1; ws_excode = 5'd4; ws_badvaddr = 32'h0000_1003; ws_pc = 32'h0000_2000;
        #1;
        check_val("nest_flush_pc", flush_pc, 32'hbfc0_0380);
        cyc();
        ws_ex = 1'b0;
        rd(5'd14, 32'hbfc0_1000, "nest_epc");
        rd(5'd8,  32'h0000_1003, "nest_badvaddr");
        rd(5'd13, 32'h8000_0010, "nest_cause");
        ws_ex = 1'b1; ws_eret = 1'b1;
        #1;
        check_val("eret_flush",    {31'd0, flush}, 32'd1);
        check_val("eret_flush_pc", flush_pc, 32'hbfc0_1000);
        cyc();
        ws_ex = 1'b0; ws_eret = 1'b0;
        rd(5'd12, 32'h0040_8001, "eret_status");
        rd(5'd13, 32'h8000_0010, "eret_cause");

        // mtc0 EPC colliding with a syscall: exception wins
        mtc0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678;
        ws_ex = 1'b1; ws_excode = 5'd8; ws_pc = 32'h0000_0400; ws_bd = 1'b0;
        cyc();
        mtc0_we = 1'b0; ws_ex = 1'b0;
        rd(5'd14, 32'h0000_0400, "coll_epc");
        rd(5'd13, 32'h0000_0020, "coll_cause");
        rd(5'd8,  32'h0000_1003, "coll_badvaddr");

        // External interrupt masked by EXL until ERET
        ext_int = 6'b000001;
        wr(5'd12, 32'h0000_0403);
        rd(5'd12, 32'h0040_0403, "mask_status");
        rd(5'd13, 32'h0000_0420, "mask_cause");
        check_val("mask_int_req", {31'd0, int_req}, 32'd0);
        ws_ex = 1'b1; ws_eret = 1'b1;
        #1;
        check_val("mask_eret_pc", flush_pc, 32'h0000_0400);
        cyc();
        ws_ex = 1'b0; ws_eret = 1'b0;
        #1;
        check_val("unmask_int_req", {31'd0, int_req}, 32'd1);
        rd(5'd12, 32'h0040_0401, "unmask_status");

        // Cause write: read shows old value, only IP[1:0] land
        mtc0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hffff_ffff;
        #1;
        check_val("no_bypass", cp0_rdata, 32'h0000_0420);
        cyc();
        mtc0_we = 1'b0;
        rd(5'd13, 32'h0000_0720, "cause_sw_ip");
        wr(5'd8, 32'hffff_ffff);
        rd(5'd8, 32'h0000_1003, "badvaddr_ro");
        rd(5'd0, 32'h0000_0000, "unmapped_addr");

        // Count wrap: two edges after the write always include one increment
        wr(5'd9, 32'hffff_ffff);
        rd(5'd9, 32'hffff_ffff, "count_written");
        cyc();
        cyc();
        rd(5'd9, 32'h0000_0000, "count_wrap");

        // Reset while an AdES exception is in write-back
        ws_ex = 1'b1; ws_excode = 5'd5; ws_badvaddr = 32'h0000_0055; ws_pc = 32'h0000_0800;
        resetn = 1'b0;
        cyc();
        resetn = 1'b1; ws_ex = 1'b0;
        #1;
        check_val("rst2_flush",   {31'd0, flush},   32'd0);
        check_val("rst2_int_req", {31'd0, int_req}, 32'd0);
        check_val("rst2_cp0_epc", cp0_epc,          32'd0);
        rd(5'd12, 32'h0040_0000, "rst2_status");
        rd(5'd8,  32'h0000_0000, "rst2_badvaddr");
        rd(5'd13, 32'h0000_0000, "rst2_cause");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
